// File: rtl/fetch_controller_if.sv
// Fetch-side bundle: AR/R read channel toward instruction memory plus the decode handoff.
// A transfer completes on the rising clock edge where valid and ready are both high. Once raised,
// valid and its payload stay unchanged until that edge. Ready may toggle freely.
interface fetch_controller_if #(
  parameter int ADDR_W = 32
);
  logic              arvalid_o;
  logic              arready_i;
  logic [ADDR_W-1:0] araddr_o;
  logic              rvalid_i;
  logic              rready_o;
  logic [31:0]       rdata_i;
  logic [1:0]        rresp_i;
  logic              valid_post_o;
  logic              ready_post_i;
  logic [31:0]       inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              branch_valid_i;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] branch_target_i;

  modport master (
    output arvalid_o, araddr_o, rready_o, valid_post_o, inst_o, pc_o,
    input  arready_i, rvalid_i, rdata_i, rresp_i, ready_post_i,
           branch_valid_i, branch_taken_i, branch_target_i
  );

  modport slave (
    input  arvalid_o, araddr_o, rready_o, valid_post_o, inst_o, pc_o,
    output arready_i, rvalid_i, rdata_i, rresp_i, ready_post_i,
           branch_valid_i, branch_taken_i, branch_target_i
  );
endinterface

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch: read one word, hand it to decode, then wait for
// decode to resolve the next PC before issuing the next read.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  fetch_controller_if.master  bus,
  output logic                fault_o,
  output logic [31:0]         inst_cnt_o,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_ADDR        = 3'd0,
    S_DATA        = 3'd1,
    S_WAIT_READY  = 3'd2,
    S_WAIT_BRANCH = 3'd3,
    S_FAULT       = 3'd4
  } state_t;

  state_t            state_q;
  logic              run_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       inst_q;
  logic [31:0]       inst_cnt_q;
  logic              fault_q;

  always_comb begin
    next_pc = bus.branch_taken_i ? bus.branch_target_i : pc_q + ADDR_W'(4);
  end

  // run_q keeps arvalid low during and on the first cycle after reset, so every
  // handshake output is low while reset is held without gating outputs on the reset pin.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_ADDR;
      run_q      <= 1'b0;
      pc_q       <= RESET_PC[ADDR_W-1:0];
      inst_q     <= '0;
      inst_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        S_ADDR: begin
          if (run_q && bus.arready_i) state_q <= S_DATA;
        end
        S_DATA: begin
          if (bus.rvalid_i) begin
            if (bus.rresp_i == 2'b00) begin
              inst_q  <= bus.rdata_i;
              state_q <= S_WAIT_READY;
            end else begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end
          end
        end
        S_WAIT_READY: begin
          if (bus.ready_post_i) begin
            inst_cnt_q <= inst_cnt_q + 32'd1;
            state_q    <= S_WAIT_BRANCH;
          end
        end
        S_WAIT_BRANCH: begin
          // A misaligned next PC is never issued; pc keeps the faulting instruction's address.
          if (bus.branch_valid_i) begin
            if (next_pc[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              pc_q    <= next_pc;
              state_q <= S_ADDR;
            end
          end
        end
        default: state_q <= S_FAULT;
      endcase
    end
  end

  assign bus.arvalid_o    = run_q && (state_q == S_ADDR);
  assign bus.araddr_o     = pc_q;
  assign bus.rready_o     = (state_q == S_DATA);
  assign bus.valid_post_o = (state_q == S_WAIT_READY);
  assign bus.inst_o       = inst_q;
  assign bus.pc_o         = pc_q;
  assign fault_o          = fault_q;
  assign inst_cnt_o       = inst_cnt_q;
  assign dbg_state        = state_q;

endmodule
